// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch unit: owns PC/IR, fetches over a req/ack handshake,
// exposes decoded IR fields and commits the next PC when the decoder retires.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  NPCOp,
  input  logic        Zero,
  input  logic        PCWr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [5:0]  OP,
  output logic [5:0]  Funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] Imm16,
  output logic [25:0] Imm26,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        instr_valid,
  output logic [31:0] InstrCnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;

  localparam logic [1:0] NPC_SEQ    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
  } ir_t;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, cnt;
  ir_t         ir;
  logic [31:0] pc_plus4, br_off, br_tgt, jmp_tgt, npc;
  logic        fetch_done, retire;

  // Acks are only meaningful while a request is outstanding.
  assign fetch_done = (state == ST_FETCH) && imem_ack;
  assign retire     = (state == ST_EXEC) && PCWr;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_FETCH;
      ST_FETCH: if (imem_ack) state_nxt = ST_EXEC;
      ST_EXEC:  if (PCWr) state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{ir[15]}}, ir[15:0], 2'b00};
  assign br_tgt   = pc_plus4 + br_off;
  assign jmp_tgt  = {pc_plus4[31:28], ir[25:0], 2'b00};

  // Reserved select 11 falls through to sequential.
  always_comb begin
    npc = pc_plus4;
    case (NPCOp)
      NPC_SEQ:    npc = pc_plus4;
      NPC_BRANCH: npc = Zero ? br_tgt : pc_plus4;
      NPC_JUMP:   npc = jmp_tgt;
      default:    npc = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
      ir    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (fetch_done) ir <= imem_rdata;
      if (retire) begin
        pc  <= npc;
        cnt <= cnt + 32'd1;
      end
    end
  end

  assign imem_req    = (state == ST_FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == ST_EXEC);

  assign OP       = ir.op;
  assign rs       = ir.rs;
  assign rt       = ir.rt;
  assign rd       = ir.rd;
  assign Funct    = ir.funct;
  assign Imm16    = ir[15:0];
  assign Imm26    = ir[25:0];
  assign PC       = pc;
  assign PC4      = pc_plus4;
  assign InstrCnt = cnt;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, randomized instruction
// stream against a PC/count reference model, and reset corner sequences.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  NPCOp;
  logic        Zero, PCWr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [5:0]  OP, Funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] Imm16;
  logic [25:0] Imm26;
  logic [31:0] PC, PC4, InstrCnt;
  logic        instr_valid;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_pc, m_cnt;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .NPCOp(NPCOp), .Zero(Zero), .PCWr(PCWr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .OP(OP), .Funct(Funct), .rs(rs), .rt(rt),
    .rd(rd), .Imm16(Imm16), .Imm26(Imm26), .PC(PC), .PC4(PC4),
    .instr_valid(instr_valid), .InstrCnt(InstrCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic [1:0]  op;
    logic        z;
    int          waits;
    int          stalls;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (pc model %h)", name, act, exp, m_pc);
    end
  endtask

  // Next-PC rules with plain integer arithmetic.
  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] w,
                                            input logic [1:0] op, input logic z);
    int off;
    logic [31:0] seq;
    seq = pc + 32'd4;
    off = $signed(w[15:0]);
    if (op == 2'b01 && z) return seq + 32'(off * 4);
    if (op == 2'b10) return (seq & 32'hF000_0000) | (32'(w[25:0]) * 32'd4);
    return seq;
  endfunction

  // One instruction: fetch with wait states, stall in EXEC, then commit.
  task automatic run_instr(input logic [31:0] word, input logic [1:0] op, input logic z,
                           input int waits, input int stalls, input logic [31:0] exp_next,
                           input bit stray);
    chk("fetch_req", {31'b0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, m_pc);
    chk("fetch_valid", {31'b0, instr_valid}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      imem_ack = 1'b0;
      tick();
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, m_pc);
      chk("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    chk("exec_valid", {31'b0, instr_valid}, 32'd1);
    chk("exec_req", {31'b0, imem_req}, 32'd0);
    chk("OP", {26'b0, OP}, {26'b0, word[31:26]});
    chk("rs_rt_rd", {17'b0, rs, rt, rd}, {17'b0, word[25:11]});
    chk("Funct", {26'b0, Funct}, {26'b0, word[5:0]});
    chk("Imm26", {6'b0, Imm26}, {6'b0, word[25:0]});
    chk("Imm16", {16'b0, Imm16}, {16'b0, word[15:0]});
    chk("exec_PC", PC, m_pc);
    chk("exec_PC4", PC4, m_pc + 32'd4);
    for (int i = 0; i < stalls; i++) begin
      PCWr = 1'b0;
      if (stray) begin
        imem_ack = 1'($urandom % 2);
        imem_rdata = $urandom;
      end
      tick();
      chk("stall_ir", {OP, Imm26}, word);
      chk("stall_pc", PC, m_pc);
      chk("stall_cnt", InstrCnt, m_cnt);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    imem_ack = 1'b0;
    NPCOp = op;
    Zero = z;
    PCWr = 1'b1;
    tick();
    PCWr = 1'b0;
    m_pc = exp_next;
    m_cnt = m_cnt + 32'd1;
    chk("next_addr", imem_addr, m_pc);
    chk("next_PC", PC, m_pc);
    chk("cnt", InstrCnt, m_cnt);
  endtask

  initial begin
    vecs[0]  = '{32'h3401_0005, 2'b00, 1'b0, 0, 0, 32'h0000_3004};
    vecs[1]  = '{32'h3401_0005, 2'b00, 1'b0, 0, 0, 32'h0000_3008};
    vecs[2]  = '{32'h3401_0005, 2'b00, 1'b0, 3, 2, 32'h0000_300C};
    vecs[3]  = '{32'h3401_0005, 2'b00, 1'b0, 0, 0, 32'h0000_3010};
    vecs[4]  = '{32'h1000_FFFF, 2'b01, 1'b1, 0, 0, 32'h0000_3010};
    vecs[5]  = '{32'h1000_FFFF, 2'b01, 1'b0, 1, 0, 32'h0000_3014};
    vecs[6]  = '{32'h1000_FFFE, 2'b01, 1'b1, 0, 0, 32'h0000_3010};
    vecs[7]  = '{32'h1000_0003, 2'b01, 1'b1, 0, 1, 32'h0000_3020};
    vecs[8]  = '{32'h0800_0C00, 2'b10, 1'b0, 0, 0, 32'h0000_3000};
    vecs[9]  = '{32'h0C00_0C05, 2'b10, 1'b1, 0, 0, 32'h0000_3014};
    vecs[10] = '{32'h3401_0005, 2'b11, 1'b1, 0, 0, 32'h0000_3018};
    vecs[11] = '{32'h1000_F3F8, 2'b01, 1'b1, 0, 0, 32'hFFFF_FFFC};
    vecs[12] = '{32'h3401_0005, 2'b00, 1'b0, 2, 0, 32'h0000_0000};

    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    NPCOp = 2'b00; Zero = 1'b0; PCWr = 1'b0;
    m_pc = 32'h0000_3000; m_cnt = '0;
    tick();
    tick();
    chk("rst_PC", PC, 32'h0000_3000);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("rst_PC4", PC4, 32'h0000_3004);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_OP", {26'b0, OP}, 32'd0);
    chk("rst_Imm26", {6'b0, Imm26}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_cnt", InstrCnt, 32'd0);
    rst = 1'b0;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("first_req", {31'b0, imem_req}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      run_instr(vecs[i].word, vecs[i].op, vecs[i].z, vecs[i].waits, vecs[i].stalls,
                vecs[i].exp_next, 1'b0);
      if (i == 2) chk("cnt_after_3", InstrCnt, 32'd3);
    end

    // Randomized stream against the model, with stray acks during stalls.
    for (int i = 0; i < 60; i++) begin
      logic [31:0] w;
      logic [1:0]  op;
      logic        z;
      w  = $urandom;
      op = 2'($urandom % 4);
      z  = 1'($urandom % 2);
      run_instr(w, op, z, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                model_npc(m_pc, w, op, z), 1'b1);
    end

    // Reset wins over an accepting ack on the same edge.
    chk("pre_rst_req", {31'b0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; rst = 1'b1;
    tick();
    chk("rstack_OP", {26'b0, OP}, 32'd0);
    chk("rstack_Imm26", {6'b0, Imm26}, 32'd0);
    chk("rstack_PC", PC, 32'h0000_3000);
    chk("rstack_req", {31'b0, imem_req}, 32'd0);
    chk("rstack_valid", {31'b0, instr_valid}, 32'd0);
    chk("rstack_cnt", InstrCnt, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_ack_ir", {OP, Imm26}, 32'd0);
    chk("idle_ack_req", {31'b0, imem_req}, 32'd1);
    chk("idle_ack_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b0;

    // Reset wins over PCWr in EXEC: no count, PC back to reset value.
    imem_ack = 1'b1; imem_rdata = 32'h3401_0005;
    tick();
    imem_ack = 1'b0;
    chk("pre_rst_exec", {31'b0, instr_valid}, 32'd1);
    PCWr = 1'b1; NPCOp = 2'b10; rst = 1'b1;
    tick();
    PCWr = 1'b0; rst = 1'b0;
    chk("rstpcwr_PC", PC, 32'h0000_3000);
    chk("rstpcwr_cnt", InstrCnt, 32'd0);
    chk("rstpcwr_ir", {OP, Imm26}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit for the MIPS CPU: owns the PC and instruction register, fetches words from instruction memory over a req/ack handshake, and presents decoded instruction fields (OP, Funct, register numbers, immediates) to the control decoder. It consumes the decoder's NPCOp/PCWr and the ALU's Zero flag to compute and commit the next PC. It sits between instruction memory and the controller/datapath.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset; bits [1:0] must be 0.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- NPCOp  in  2  next-PC select: 00 PC+4, 01 branch-if-Zero, 10 jump (j/jal), 11 reserved (treated as 00)
- Zero  in  1  ALU equality flag for branch
- PCWr  in  1  commit next PC and retire current instruction (sampled in EXEC only)
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch byte address (= PC)
- imem_ack  in  1  memory has valid imem_rdata this cycle
- imem_rdata  in  32  fetched instruction word
- OP  out  6  IR[31:26]
- Funct  out  6  IR[5:0]
- rs, rt, rd  out  5 each  IR[25:21], IR[20:16], IR[15:11]
- Imm16  out  16  IR[15:0]
- Imm26  out  26  IR[25:0]
- PC  out  32  address of instruction in IR
- PC4  out  32  PC+4 (jal link value)
- instr_valid  out  1  IR holds a fetched, not-yet-retired instruction
- InstrCnt  out  32  retired-instruction counter

## Operation
- States: IDLE, FETCH, EXEC.
- Reset (any edge with rst=1, overrides everything): state=IDLE, PC=RESET_PC, IR=0, InstrCnt=0. In-flight handshake abandoned; acks while in IDLE ignored.
- IDLE: imem_req=0, instr_valid=0; unconditionally → FETCH next edge when rst=0.
- FETCH: imem_req=1, imem_addr=PC, held stable until ack. On edge with imem_ack=1: IR<=imem_rdata, → EXEC. ack=0: remain.
- EXEC: imem_req=0, instr_valid=1. PCWr=0: hold state, PC and IR (stall). PCWr=1: PC<=NPC, InstrCnt<=InstrCnt+1, → FETCH.
- imem_ack outside FETCH is ignored (no IR write).
- NPC, all arithmetic 32-bit modulo 2^32 (wraps silently):
  - 00/11: PC+4
  - 01: Zero ? PC+4+(signext(Imm16)<<2) : PC+4
  - 10: {PC4[31:28], Imm26, 2'b00}
- NPC is combinational from PC, IR, NPCOp, Zero; only registered on PCWr in EXEC.
- PC4 = PC+4 combinational; field outputs are direct IR slices.
- InstrCnt wraps 0xFFFF_FFFF → 0.

## Timing
- Outputs after reset edge: imem_req=0, imem_addr=RESET_PC, all IR fields 0, instr_valid=0, PC=RESET_PC, PC4=RESET_PC+4, InstrCnt=0.
- First imem_req=1 in the 2nd cycle after rst deasserts (one IDLE cycle).
- Zero-wait memory (ack in first FETCH cycle) + PCWr=1 on first EXEC cycle: 2 cycles per instruction. Each memory wait cycle adds 1; each PCWr=0 EXEC cycle adds 1.
- Fields/instr_valid update the cycle after the accepting ack edge; PC updates the cycle after the PCWr edge, and imem_addr reflects it in the same cycle.
- rst coincident with ack or PCWr: reset wins; no IR write, no count.

## Test plan
- Reset: hold rst 2 cycles → PC=0x00003000, imem_req=0, OP=0, instr_valid=0, InstrCnt=0; imem_req=1 exactly 2 cycles after release.
- Zero-wait stream: ack each FETCH with 0x34010005 (ori), NPCOp=00, PCWr=1 → imem_addr 0x3000, 0x3004, 0x3008 on 2-cycle spacing; OP=0x0D, rt=1, Imm16=0x0005; InstrCnt=3.
- Wait states + stall: ack delayed 3 cycles → imem_addr stable, instr_valid=0 throughout; then PCWr=0 for 2 EXEC cycles → PC, IR, InstrCnt unchanged.
- Branch at PC=0x3010, NPCOp=01: Imm16=0xFFFF, Zero=1 → next PC 0x3010; Zero=0 → 0x3014; Imm16=0x0003, Zero=1 → 0x3020.
- jal 0x0C000C05 at PC=0x3000, NPCOp=10 → PC4=0x3004, next PC=0x00003014; PC=0xFFFFFFFC, NPCOp=00 → wraps to 0x00000000.
- Reset mid-FETCH with imem_ack=1 same edge → IR stays 0, PC=RESET_PC, state IDLE; later stray ack in IDLE/EXEC → no IR change.
